ni_vc_tx_scheduler: RTL and testbench
=====================================

Name: ni_vc_tx_scheduler

Overview:
- Packet-level round-robin scheduler that shares the network interface's single flit path toward the router local port among the N_VC per-virtual-channel TX flit sources.
- Sits between the per-VC write-side flit buffers (fed by the AXI slave / packet generator) and the router local input port.
- Grants one VC per packet and holds the grant until that packet's tail flit is accepted, so flits of different packets never interleave.

Parameters:
- N_VC, 3, number of virtual channels / requesters (≥2).
- FLIT_DATA_W, 32, flit payload width.
- PKT_LEN_W, 8, width of the packet length field (flits minus one, AXI alen style).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- arst_n  in  1  reset; synchronous, active-low.
- vc_valid_i  in  N_VC  per-VC flit available.
- vc_len_i  in  N_VC*PKT_LEN_W  per-VC packet length minus one; valid while the VC presents its head flit.
- vc_flit_i  in  N_VC*FLIT_DATA_W  per-VC flit payload.
- vc_ready_o  out  N_VC  per-VC flit accepted (pop strobe).
- flit_valid_o  out  1  output flit valid.
- flit_data_o  out  FLIT_DATA_W  output flit payload.
- flit_vc_o  out  $clog2(N_VC)  VC id of the output flit.
- flit_head_o  out  1  output flit is the packet head.
- flit_tail_o  out  1  output flit is the packet tail.
- flit_ready_i  in  1  router local port accepts the flit.
- busy_o  out  1  a packet is locked (FSM in SEND).

Behaviour:
- Reset (arst_n low at a clk edge):
  - FSM goes to IDLE; rr_ptr=0; grant=0; beat_cnt=0; len_q=0.
  - All outputs 0.
  - Reset mid-packet abandons the packet with no tail emitted. Upstream is also reset.
- FSM has two states, IDLE and SEND.
- IDLE:
  - If vc_valid_i is nonzero, pick the first set bit scanning from rr_ptr upward, wrapping modulo N_VC.
  - Register grant=picked, len_q=vc_len_i[picked], beat_cnt=0, and go to SEND.
  - Outputs stay 0 in IDLE, so grant latency is 1 cycle and the head flit is presented on the cycle after the request is seen.
  - If no VC is valid, stay in IDLE.
- SEND:
  - flit_valid_o=vc_valid_i[grant]; flit_data_o=vc_flit_i[grant]; flit_vc_o=grant.
  - flit_head_o=(beat_cnt==0)&flit_valid_o; flit_tail_o=(beat_cnt==len_q)&flit_valid_o.
  - vc_ready_o[grant]=vc_valid_i[grant]&flit_ready_i; all other bits 0.
  - A transfer happens when flit_valid_o&flit_ready_i.
  - Non-tail transfer: beat_cnt+1.
  - Tail transfer: go to IDLE; rr_ptr=(grant==N_VC-1)?0:grant+1; beat_cnt=0.
  - busy_o=1 throughout SEND.
- Lock rules:
  - If the granted VC drops valid mid-packet, stall (flit_valid_o=0) and keep the lock. Other VCs are never granted until the tail.
  - len_q is captured at grant only; later changes on vc_len_i are ignored.
  - len_q=0 gives a single-flit packet: head and tail asserted on the same flit.
  - len_q=2^PKT_LEN_W-1 gives the maximum packet length; beat_cnt is PKT_LEN_W bits wide and never wraps, because the tail is reached first.
- After a tail transfer there is one mandatory IDLE bubble cycle, even when other VCs are requesting.
- flit_ready_i high while flit_valid_o is low has no effect.
- vc_valid_i asserted by a non-granted VC has no effect until the next IDLE.

Optional Feature:
- Macro: NI_TX_STRICT_PRIO_EN.
- Defined: IDLE picks the highest-indexed valid VC (VC N_VC-1 has top priority); rr_ptr is not used and stays 0. Packet lock and all other behaviour are unchanged.
- Undefined: round-robin as specified above.

Test Plan:
- Single VC: VC1 valid, len=2, data A,B,C, flit_ready_i=1.
  - Cycle 0: IDLE.
  - Cycles 1-3: flit_vc_o=1, data A,B,C; head on A, tail on C.
  - Cycle 4: IDLE, rr_ptr=2.
- Fairness: all 3 VCs continuously valid, len=0, ready=1.
  - Grants are 0,1,2,0,1,2, with one flit every 2 cycles.
  - With NI_TX_STRICT_PRIO_EN, all grants go to VC2.
- Backpressure: VC0 len=3, flit_ready_i low on beat 1 for 3 cycles.
  - flit_data_o holds beat 1 and vc_ready_o[0]=0 during the stall.
  - Tail arrives on the 4th accepted flit; beat_cnt never skips.
- Source gap with competitor: VC2 granted, len=1, drops valid after the head for 2 cycles while VC0 is valid.
  - No VC0 flit appears.
  - VC2 tail is sent next; VC0 is granted after the IDLE bubble.
- Length capture: VC1 len=1 at grant, vc_len_i changes to 5 mid-packet.
  - Tail is asserted on the 2nd flit.
- Reset mid-packet: arst_n low during beat 2 of a len=4 VC0 packet.
  - Next cycle all outputs are 0 and the FSM is IDLE.
  - After release, with VC0 and VC1 valid, VC0 is granted first (rr_ptr=0).

Source files
------------

// File: rtl/ni_vc_tx_scheduler.sv
// ni_vc_tx_scheduler: packet-level arbiter sharing the NI flit path toward the
// router local port among N_VC per-VC TX flit sources. One VC is granted per
// packet and the grant is held until that packet's tail flit is accepted.
// Optional build macro NI_TX_STRICT_PRIO_EN: IDLE picks the highest-indexed
// valid VC instead of the round-robin choice; rr_ptr then stays 0.
module ni_vc_tx_scheduler #(
  parameter int N_VC        = 3,
  parameter int FLIT_DATA_W = 32,
  parameter int PKT_LEN_W   = 8
) (
  input  logic                          clk,
  input  logic                          arst_n,
  input  logic [N_VC-1:0]               vc_valid_i,
  input  logic [N_VC*PKT_LEN_W-1:0]     vc_len_i,
  input  logic [N_VC*FLIT_DATA_W-1:0]   vc_flit_i,
  output logic [N_VC-1:0]               vc_ready_o,
  output logic                          flit_valid_o,
  output logic [FLIT_DATA_W-1:0]        flit_data_o,
  output logic [$clog2(N_VC)-1:0]       flit_vc_o,
  output logic                          flit_head_o,
  output logic                          flit_tail_o,
  input  logic                          flit_ready_i,
  output logic                          busy_o
);

  localparam int VC_W = $clog2(N_VC);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [VC_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [VC_W-1:0]        grant_q, grant_d;
  logic [PKT_LEN_W-1:0]   len_q, len_d;
  logic [PKT_LEN_W-1:0]   beat_q, beat_d;

  logic [VC_W-1:0]        pick;
  logic                   pick_vld;
  logic [PKT_LEN_W-1:0]   pick_len;
  logic                   g_valid;
  logic [FLIT_DATA_W-1:0] g_flit;

  // Arbiter: choose the VC to lock when the FSM is idle
`ifdef NI_TX_STRICT_PRIO_EN
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    // Ascending scan, last hit wins, so the highest index has priority
    for (int unsigned k = 0; k < N_VC; k++) begin
      if (vc_valid_i[k]) begin
        pick     = VC_W'(k);
        pick_vld = 1'b1;
      end
    end
  end
`else
  always_comb begin : rr_scan
    int unsigned idx;
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    // Scan from rr_ptr upward, wrapping modulo N_VC; first hit wins
    for (int unsigned k = 0; k < N_VC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_VC) idx = idx - N_VC;
      if (!pick_vld && vc_valid_i[idx]) begin
        pick     = VC_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end
`endif

  // Select the granted VC's flit/valid and the candidate VC's length field
  always_comb begin
    g_valid  = 1'b0;
    g_flit   = '0;
    pick_len = '0;
    for (int unsigned k = 0; k < N_VC; k++) begin
      if (grant_q == VC_W'(k)) begin
        g_valid = vc_valid_i[k];
        g_flit  = vc_flit_i[k*FLIT_DATA_W +: FLIT_DATA_W];
      end
      if (pick == VC_W'(k)) begin
        pick_len = vc_len_i[k*PKT_LEN_W +: PKT_LEN_W];
      end
    end
  end

  // Next-state and output logic; outputs are all zero outside SEND
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    len_d        = len_q;
    beat_d       = beat_q;
    vc_ready_o   = '0;
    flit_valid_o = 1'b0;
    flit_data_o  = '0;
    flit_vc_o    = '0;
    flit_head_o  = 1'b0;
    flit_tail_o  = 1'b0;
    busy_o       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          len_d   = pick_len;
          beat_d  = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        busy_o       = 1'b1;
        flit_valid_o = g_valid;
        flit_data_o  = g_flit;
        flit_vc_o    = grant_q;
        flit_head_o  = (beat_q == '0) & g_valid;
        flit_tail_o  = (beat_q == len_q) & g_valid;
        for (int unsigned k = 0; k < N_VC; k++) begin
          vc_ready_o[k] = (grant_q == VC_W'(k)) & g_valid & flit_ready_i;
        end
        if (g_valid && flit_ready_i) begin
          if (beat_q == len_q) begin
            state_d = IDLE;
            beat_d  = '0;
`ifndef NI_TX_STRICT_PRIO_EN
            rr_ptr_d = (grant_q == VC_W'(N_VC - 1)) ? '0 : grant_q + VC_W'(1);
`endif
          end else begin
            beat_d = beat_q + PKT_LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      len_q    <= '0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
    end
  end

endmodule

// File: tb/tb_ni_vc_tx_scheduler.sv
// Self-checking bench for ni_vc_tx_scheduler: per-VC packet sources plus a
// packet-level reference model of the lock / round-robin rules.
// Honours NI_TX_STRICT_PRIO_EN the same way the design does.
module tb_ni_vc_tx_scheduler;

  localparam int N  = 3;
  localparam int FW = 32;
  localparam int LW = 8;
  localparam int VW = 2;

  logic            clk = 1'b0;
  logic            arst_n;
  logic [N-1:0]    vc_valid_i;
  logic [N*LW-1:0] vc_len_i;
  logic [N*FW-1:0] vc_flit_i;
  logic [N-1:0]    vc_ready_o;
  logic            flit_valid_o;
  logic [FW-1:0]   flit_data_o;
  logic [VW-1:0]   flit_vc_o;
  logic            flit_head_o;
  logic            flit_tail_o;
  logic            flit_ready_i;
  logic            busy_o;

  always #5 clk = ~clk;

  ni_vc_tx_scheduler #(.N_VC(N), .FLIT_DATA_W(FW), .PKT_LEN_W(LW)) dut (
    .clk(clk), .arst_n(arst_n), .vc_valid_i(vc_valid_i), .vc_len_i(vc_len_i),
    .vc_flit_i(vc_flit_i), .vc_ready_o(vc_ready_o), .flit_valid_o(flit_valid_o),
    .flit_data_o(flit_data_o), .flit_vc_o(flit_vc_o), .flit_head_o(flit_head_o),
    .flit_tail_o(flit_tail_o), .flit_ready_i(flit_ready_i), .busy_o(busy_o)
  );

  int tests = 0;
  int fails = 0;

  // Sources: each VC always holds a packet of s_len+1 flits, at beat s_beat
  int unsigned s_len[N], s_beat[N], s_id[N], next_len[N];
  bit          rand_len  = 1'b0;
  bit          noise_on  = 1'b0;
  int unsigned noise_len = 0;
  logic [N-1:0] en      = '0;
  logic         rdy     = 1'b1;
  logic         rst_req = 1'b0;

  // Reference model: packet lock state and the VC after the last one served
  bit          m_busy = 1'b0;
  int unsigned m_vc = 0, m_sent = 0, m_len = 0, m_next = 0;

  logic [40:0]   obs_v, exp_v;
  logic          o_fv, o_h, o_t, o_busy, e_fv;
  logic [VW-1:0] o_vc;
  logic [FW-1:0] o_data;
  logic [N-1:0]  o_rdy;

  function automatic logic [FW-1:0] flit_of(int unsigned v);
    return {8'(v), 8'(s_id[v]), 16'(s_beat[v])};
  endfunction

  function automatic int unsigned gen_len(int unsigned v);
    int unsigned r;
    if (!rand_len) return next_len[v];
    r = $urandom_range(0, 31);
    return (r == 0) ? 255 : (r % 4);
  endfunction

  task automatic new_pkt(int unsigned v);
    s_beat[v] = 0;
    s_id[v]   = s_id[v] + 1;
    s_len[v]  = gen_len(v);
  endtask

  // One clock: drive, sample at negedge, predict, then advance model and sources
  task automatic tick();
    logic [N-1:0]  e_rdy;
    logic [FW-1:0] e_data;
    logic [VW-1:0] e_vc;
    logic          e_h, e_t;
    int unsigned   pv;
    bit            found;
    arst_n       = !rst_req;
    flit_ready_i = rdy;
    vc_valid_i   = en;
    for (int v = 0; v < N; v++) begin
      vc_len_i[v*LW +: LW]  = (noise_on && s_beat[v] != 0) ? LW'(noise_len) : LW'(s_len[v]);
      vc_flit_i[v*FW +: FW] = flit_of(v);
    end
    @(negedge clk);
    o_rdy = vc_ready_o; o_fv = flit_valid_o; o_data = flit_data_o; o_vc = flit_vc_o;
    o_h = flit_head_o; o_t = flit_tail_o; o_busy = busy_o;
    obs_v = {o_rdy, o_fv, o_data, o_vc, o_h, o_t, o_busy};
    e_rdy = '0; e_fv = 1'b0; e_data = '0; e_vc = '0; e_h = 1'b0; e_t = 1'b0;
    if (m_busy) begin
      e_fv   = vc_valid_i[m_vc];
      e_data = flit_of(m_vc);
      e_vc   = VW'(m_vc);
      e_h    = e_fv && (m_sent == 0);
      e_t    = e_fv && (m_sent == m_len);
      if (e_fv && rdy) e_rdy[m_vc] = 1'b1;
    end
    exp_v = {e_rdy, e_fv, e_data, e_vc, e_h, e_t, m_busy};
    @(posedge clk);
    if (rst_req) begin
      m_busy = 1'b0; m_next = 0; m_sent = 0;
      for (int v = 0; v < N; v++) new_pkt(v);
    end else begin
      if (!m_busy) begin
        found = 1'b0; pv = 0;
`ifdef NI_TX_STRICT_PRIO_EN
        for (int i = N - 1; i >= 0; i--)
          if (!found && vc_valid_i[i]) begin found = 1'b1; pv = i; end
`else
        for (int k = 0; k < N; k++)
          if (!found && vc_valid_i[(m_next + k) % N]) begin found = 1'b1; pv = (m_next + k) % N; end
`endif
        if (found) begin
          m_busy = 1'b1; m_vc = pv; m_sent = 0; m_len = vc_len_i[pv*LW +: LW];
        end
      end else if (e_fv && rdy) begin
        if (m_sent == m_len) begin
          m_busy = 1'b0; m_next = (m_vc + 1) % N;
        end else begin
          m_sent++;
        end
      end
      for (int v = 0; v < N; v++) begin
        if (o_rdy[v]) begin
          s_beat[v]++;
          if (s_beat[v] > s_len[v]) new_pkt(v);
        end
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    en = '0; rdy = 1'b1; rst_req = 1'b1;
    tick(); tick();
    rst_req = 1'b0;
  endtask

  task automatic test_reset();
    en = '1; rdy = 1'b1; rst_req = 1'b1;
    tick();  // DUT state is unknown before the first reset edge
    for (int c = 0; c < 2; c++) begin
      tick();
      tests++;
      if (obs_v !== exp_v || o_busy !== 1'b0 || o_rdy !== '0) begin
        fails++; $display("FAIL reset cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
    end
    rst_req = 1'b0;
  endtask

  task automatic test_single_vc();
    bit ok;
    next_len = '{2, 2, 2};
    apply_reset();
    en = 3'b010;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL single_model cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (c >= 1 && c <= 3)
        ok = o_fv && o_vc == 2'd1 && o_data[15:0] == 16'(c - 1) && o_h == (c == 1) && o_t == (c == 3);
      else
        ok = !o_fv && !o_busy;
      tests++;
      if (!ok) begin
        fails++; $display("FAIL single_seq cyc=%0d got vc=%0d data=%h h=%b t=%b busy=%b", c, o_vc, o_data, o_h, o_t, o_busy);
      end
    end
  endtask

  task automatic test_fairness();
    int unsigned got[$];
    int unsigned want;
    next_len = '{0, 0, 0};
    apply_reset();
    en = '1;
    for (int c = 0; c < 12; c++) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL fair_model cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (o_fv) got.push_back(o_vc);
    end
    tests++;
    if (got.size() != 6) begin
      fails++; $display("FAIL fair_count got=%0d want=6", got.size());
    end
    for (int i = 0; i < got.size() && i < 6; i++) begin
`ifdef NI_TX_STRICT_PRIO_EN
      want = 2;
`else
      want = i % 3;
`endif
      tests++;
      if (got[i] != want) begin
        fails++; $display("FAIL fair_grant idx=%0d got=%0d want=%0d", i, got[i], want);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    next_len = '{3, 0, 0};
    apply_reset();
    en = 3'b001; acc = 0;
    for (int c = 0; c < 9; c++) begin
      rdy = !(c >= 2 && c <= 4);
      tick();
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL bp_model cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (c >= 2 && c <= 4) begin
        tests++;
        if (!(o_fv && o_data[15:0] == 16'd1 && o_rdy == '0)) begin
          fails++; $display("FAIL bp_hold cyc=%0d got data=%h rdy=%b want data beat 1 rdy=0", c, o_data, o_rdy);
        end
      end
      if (o_fv && rdy) begin
        acc++;
        tests++;
        if (o_t !== (acc == 4) || o_data[15:0] !== 16'(acc - 1)) begin
          fails++; $display("FAIL bp_beat acc=%0d got tail=%b beat=%0d", acc, o_t, o_data[15:0]);
        end
      end
    end
    rdy = 1'b1;
  endtask

  task automatic test_source_gap();
    logic [N-1:0] tbl [8];
    bit ok;
    tbl = '{3'b100, 3'b101, 3'b001, 3'b001, 3'b101, 3'b101, 3'b101, 3'b101};
    next_len = '{1, 1, 1};
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      en = tbl[c];
      tick();
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL gap_model cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      ok = 1'b1;
      if (c == 1) ok = o_fv && o_vc == 2'd2 && o_h;
      if (c == 2 || c == 3) ok = !o_fv && o_rdy == '0 && o_busy;
      if (c == 4) ok = o_fv && o_vc == 2'd2 && o_t;
      if (c == 5) ok = !o_busy && !o_fv;
`ifdef NI_TX_STRICT_PRIO_EN
      if (c == 6) ok = o_fv && o_vc == 2'd2 && o_h;
`else
      if (c == 6) ok = o_fv && o_vc == 2'd0 && o_h;
`endif
      tests++;
      if (!ok) begin
        fails++; $display("FAIL gap_seq cyc=%0d got vc=%0d fv=%b h=%b t=%b busy=%b", c, o_vc, o_fv, o_h, o_t, o_busy);
      end
    end
  endtask

  task automatic test_len_capture();
    next_len = '{0, 1, 0};
    noise_on = 1'b1; noise_len = 5;
    apply_reset();
    en = 3'b010;
    for (int c = 0; c < 4; c++) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL len_model cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (c == 2) begin
        tests++;
        if (!(o_fv && o_t && o_data[15:0] == 16'd1)) begin
          fails++; $display("FAIL len_tail got tail=%b beat=%0d want tail=1 beat=1", o_t, o_data[15:0]);
        end
      end
    end
    noise_on = 1'b0;
  endtask

  task automatic test_reset_mid();
    next_len = '{4, 0, 0};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      en      = (c >= 4) ? 3'b011 : 3'b001;
      rst_req = (c == 3);
      tick();
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL rmid_model cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (c == 4) begin
        tests++;
        if (o_fv || o_busy || o_rdy != '0 || o_data != '0) begin
          fails++; $display("FAIL rmid_zero got=%h want all zero", obs_v);
        end
      end
      if (c == 5) begin
        tests++;
`ifdef NI_TX_STRICT_PRIO_EN
        if (!(o_fv && o_h && o_vc == 2'd1)) begin
`else
        if (!(o_fv && o_h && o_vc == 2'd0)) begin
`endif
          fails++; $display("FAIL rmid_grant got vc=%0d fv=%b h=%b", o_vc, o_fv, o_h);
        end
      end
    end
    rst_req = 1'b0;
  endtask

  task automatic test_max_len();
    int tail_at;
    next_len = '{255, 0, 0};
    apply_reset();
    en = 3'b001; tail_at = -1;
    for (int c = 0; c < 259; c++) begin
      tick();
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL maxlen_model cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
      if (o_t && tail_at < 0) tail_at = c;
    end
    tests++;
    if (tail_at != 256) begin
      fails++; $display("FAIL maxlen_tail got cyc=%0d want 256", tail_at);
    end
  endtask

  task automatic test_random();
    rand_len = 1'b1; noise_on = 1'b1;
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      for (int v = 0; v < N; v++) en[v] = ($urandom_range(0, 3) != 0);
      rdy       = ($urandom_range(0, 9) < 7);
      rst_req   = ($urandom_range(0, 299) == 0);
      noise_len = $urandom_range(0, 255);
      tick();
      tests++;
      if (obs_v !== exp_v) begin
        fails++; $display("FAIL random cyc=%0d got=%h exp=%h", c, obs_v, exp_v);
      end
    end
    rst_req = 1'b0; rand_len = 1'b0; noise_on = 1'b0;
  endtask

  initial begin
    for (int v = 0; v < N; v++) begin
      s_len[v] = 0; s_beat[v] = 0; s_id[v] = 0; next_len[v] = 0;
    end
    arst_n = 1'b0; vc_valid_i = '0; vc_len_i = '0; vc_flit_i = '0; flit_ready_i = 1'b0;
    #1;
    test_reset();
    test_single_vc();
    test_fairness();
    test_backpressure();
    test_source_gap();
    test_len_capture();
    test_reset_mid();
    test_max_len();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
